// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer built around a single full-adder cell.
// Operands enter through a valid/ready handshake. They are processed LSB-first,
// one bit per clock. The result (sum, carry-out, signed overflow) leaves through
// a second valid/ready handshake.

// One-bit full adder, the only arithmetic cell in the datapath.
module fadder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | shifting one bit per cycle through fadder, cnt = bit index
// DONE  | result presented, out_valid=1, held until out_ready
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] ra, rb, res;
    logic [WIDTH-1:0] sum_q;
    logic            carry, cout_q, ovf_q;
    logic [CW-1:0]   cnt;
    logic            accept, shift_en, last_bit;
    logic            fa_s, fa_co;

    fadder u_fadder (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; handshake outputs come straight from the state register.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        shift_en  = 1'b0;
        last_bit  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                shift_en = 1'b1;
                if (cnt == LAST_BIT) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/result shift registers, carry and bit counter. Subtraction is
    // A + ~B + 1, so B is inverted at load and the carry is seeded with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            ra    <= a;
            rb    <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
        end else if (shift_en) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            res   <= {fa_s, res[WIDTH-1:1]};
            carry <= fa_co;
            if (!last_bit) cnt <= cnt + CW'(1);
        end
    end

    // Output registers loaded on the final bit; they keep their value after
    // the result handshake. Overflow is carry-into-MSB XOR carry-out-of-MSB,
    // and on the last bit the carry register still holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_bit) begin
            sum_q  <= {fa_s, res[WIDTH-1:1]};
            cout_q <= fa_co;
            ovf_q  <= carry ^ fa_co;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vector table,
// randomized operations against an arithmetic reference, backpressure and
// mid-operation reset sequences.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed range for ovf.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] esum, output logic ecout, output logic eovf);
        int ua, ub, sa, sb, full, sres;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (msub) begin
            full = ua + (255 - ub) + 1;
            sres = sa - sb;
        end else begin
            full = ua + ub;
            sres = sa + sb;
        end
        esum  = W'(full % 256);
        ecout = (full >= 256);
        eovf  = (sres > 127) || (sres < -128);
    endtask

    // One complete operation: accept, check latency, optionally stall, check result, handshake.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                          input int hold, input logic [W-1:0] esum, input logic ecout,
                          input logic eovf, input string tag);
        int k;
        @(negedge clk);
        a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b0;
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(W));
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, 32'(out_valid), 32'd1);
        end
        chk({tag, " sum"},  32'(sum),  32'(esum));
        chk({tag, " cout"}, 32'(cout), 32'(ecout));
        chk({tag, " ovf"},  32'(ovf),  32'(eovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " post in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        logic [W-1:0] rs, hs;
        logic rc, ro, hc, ho;
        int k;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};

        #12;
        chk("reset in_ready",  32'(in_ready),  32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset sum",       32'(sum),       32'd0);
        chk("reset cout",      32'(cout),      32'd0);
        chk("reset ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, 0,
                   vecs[i].esum, vecs[i].ecout, vecs[i].eovf, $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra_, rb_;
            logic rsub_;
            ra_ = W'($urandom);
            rb_ = W'($urandom);
            rsub_ = 1'($urandom);
            model(ra_, rb_, rsub_, rs, rc, ro);
            run_op(ra_, rb_, rsub_, int'($urandom_range(0, 3)), rs, rc, ro,
                   $sformatf("rnd%0d", i));
        end

        // Backpressure: DONE held 5 cycles while new requests are offered.
        model(8'h12, 8'h34, 1'b0, hs, hc, ho);
        @(negedge clk);
        a = 8'h12; b = 8'h34; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("bp latency", 32'(k), 32'(W));
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready",  32'(in_ready),  32'd0);
            chk("bp sum",       32'(sum),       32'(hs));
            chk("bp cout",      32'(cout),      32'(hc));
            chk("bp ovf",       32'(ovf),       32'(ho));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp after out_valid", 32'(out_valid), 32'd0);
        chk("bp after in_ready",  32'(in_ready),  32'd1);
        chk("bp after sum kept",  32'(sum),       32'(hs));
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            chk("bp no stray op out_valid", 32'(out_valid), 32'd0);
            chk("bp no stray op in_ready",  32'(in_ready),  32'd1);
        end

        // Reset three cycles into RUN.
        @(negedge clk);
        a = 8'h33; b = 8'h44; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst in_ready",  32'(in_ready),  32'd1);
        chk("arst out_valid", 32'(out_valid), 32'd0);
        chk("arst sum",       32'(sum),       32'd0);
        chk("arst cout",      32'(cout),      32'd0);
        chk("arst ovf",       32'(ovf),       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            chk("post-reset out_valid", 32'(out_valid), 32'd0);
        end
        run_op(8'h01, 8'h01, 1'b0, 0, 8'h02, 1'b0, 1'b0, "after reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
